// File: rtl/fb_fill_ctrl.sv
// rtl/fb_fill_ctrl.sv - rectangle/clear fill engine driving a framebuffer write port
//
// Accepts CLEAR or RECT commands, clips the rectangle to the framebuffer and
// emits one pixel write per enabled cycle in raster order (x fastest).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only when idle)
//   cmd_op                        1=CLEAR, 2=RECT, 0/3 invalid (completes with no writes)
//   cmd_x/cmd_y/cmd_w/cmd_h       rectangle origin and size (unused for CLEAR)
//   cmd_color                     fill color
//   vblank                        write gate when VBLANK_ONLY=1
//   busy, done                    not-idle flag, one-cycle completion pulse
//   fb_we/fb_x/fb_y/fb_color      framebuffer write port
module fb_fill_ctrl #(
  parameter int XY_BITW     = 16,
  parameter int WIDTH       = 100,
  parameter int HEIGHT      = 100,
  parameter int COLORW      = 3,
  parameter int VBLANK_ONLY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [XY_BITW-1:0] cmd_x,
  input  logic [XY_BITW-1:0] cmd_y,
  input  logic [XY_BITW-1:0] cmd_w,
  input  logic [XY_BITW-1:0] cmd_h,
  input  logic [COLORW-1:0]  cmd_color,
  input  logic               vblank,
  output logic               busy,
  output logic               done,
  output logic               fb_we,
  output logic [XY_BITW-1:0] fb_x,
  output logic [XY_BITW-1:0] fb_y,
  output logic [COLORW-1:0]  fb_color
);

  localparam int XW1 = XY_BITW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Extents are kept one bit wider so that x+w never wraps.
  localparam logic [XY_BITW:0]   LP_W    = XW1'(WIDTH);
  localparam logic [XY_BITW:0]   LP_H    = XW1'(HEIGHT);
  localparam logic [XY_BITW:0]   LP_ONE1 = XW1'(1);
  localparam logic [XY_BITW-1:0] LP_ONE  = XY_BITW'(1);

  logic [1:0]         r_state;
  logic [XY_BITW-1:0] r_x;
  logic [XY_BITW-1:0] r_y;
  logic [XY_BITW-1:0] r_x0;
  logic [XY_BITW:0]   r_xend;
  logic [XY_BITW:0]   r_yend;
  logic [COLORW-1:0]  r_color;

  logic               w_is_clear;
  logic               w_is_rect;
  logic [XY_BITW-1:0] w_x0;
  logic [XY_BITW-1:0] w_y0;
  logic [XY_BITW:0]   w_xsum;
  logic [XY_BITW:0]   w_ysum;
  logic [XY_BITW:0]   w_xend;
  logic [XY_BITW:0]   w_yend;
  logic               w_empty;
  logic               w_en;
  logic               w_x_last;
  logic               w_y_last;

  // Command decode and clipping, evaluated against the live cmd_* inputs.
  always_comb begin
    w_is_clear = (cmd_op == 2'd1);
    w_is_rect  = (cmd_op == 2'd2);
    w_xsum     = {1'b0, cmd_x} + {1'b0, cmd_w};
    w_ysum     = {1'b0, cmd_y} + {1'b0, cmd_h};
    if (w_is_clear) begin
      w_x0   = '0;
      w_y0   = '0;
      w_xend = LP_W;
      w_yend = LP_H;
    end else begin
      w_x0   = cmd_x;
      w_y0   = cmd_y;
      w_xend = (w_xsum > LP_W) ? LP_W : w_xsum;
      w_yend = (w_ysum > LP_H) ? LP_H : w_ysum;
    end
    // An origin at or beyond the clipped end covers zero size and off-screen origins alike.
    w_empty = !(w_is_clear || w_is_rect) ||
              (w_xend <= {1'b0, w_x0}) ||
              (w_yend <= {1'b0, w_y0});
  end

  assign w_en     = (VBLANK_ONLY == 0) || vblank;
  assign w_x_last = (({1'b0, r_x} + LP_ONE1) == r_xend);
  assign w_y_last = (({1'b0, r_y} + LP_ONE1) == r_yend);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_x0    <= '0;
      r_xend  <= '0;
      r_yend  <= '0;
      r_color <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (w_empty) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_FILL;
              r_x     <= w_x0;
              r_y     <= w_y0;
              r_x0    <= w_x0;
              r_xend  <= w_xend;
              r_yend  <= w_yend;
              r_color <= cmd_color;
            end
          end
        end
        S_FILL: begin
          // Counters only move on cycles where a write is actually issued.
          if (w_en) begin
            if (w_x_last) begin
              if (w_y_last) begin
                r_state <= S_DONE;
              end else begin
                r_x <= r_x0;
                r_y <= r_y + LP_ONE;
              end
            end else begin
              r_x <= r_x + LP_ONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign fb_we     = (r_state == S_FILL) && w_en;
  assign fb_x      = r_x;
  assign fb_y      = r_y;
  assign fb_color  = r_color;

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// tb/tb_fb_fill_ctrl.sv - scoreboard bench for fb_fill_ctrl (ungated and vblank-gated instances)
module tb_fb_fill_ctrl;

  localparam int W = 100;
  localparam int H = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [15:0]       cmd_x, cmd_y, cmd_w, cmd_h;
  logic [2:0]        cmd_color;
  logic              vblank;

  logic [1:0]        rdy, bsy, dn, we;
  logic [1:0][15:0]  fx, fy;
  logic [1:0][2:0]   fc;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t exq[2][$];
  int   pend_n[2][$];
  int   acc[2];
  int   wcnt[2];
  int   last_done[2];
  bit   prev_done[2];
  int   acc_hist[$];
  int   done_hist[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   vb_mode = 0;

  fb_fill_ctrl #(.XY_BITW(16), .WIDTH(W), .HEIGHT(H), .COLORW(3), .VBLANK_ONLY(0)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .vblank(vblank), .busy(bsy[0]), .done(dn[0]), .fb_we(we[0]), .fb_x(fx[0]),
    .fb_y(fy[0]), .fb_color(fc[0])
  );

  fb_fill_ctrl #(.XY_BITW(16), .WIDTH(W), .HEIGHT(H), .COLORW(3), .VBLANK_ONLY(1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .vblank(vblank), .busy(bsy[1]), .done(dn[1]), .fb_we(we[1]), .fb_x(fx[1]),
    .fb_y(fy[1]), .fb_color(fc[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (vb_mode == 1) vblank = 1'($urandom_range(0, 1));
    else if (vb_mode == 0) vblank = 1'b1;
  end

  task automatic chk(input string nm, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=expired want=event (cycle %0d)", nm, cyc);
  endtask

  // Reference model: clipped rectangle expanded into its raster-order pixel list.
  task automatic push_model(input int op, input int x, input int y, input int w,
                            input int h, input int c);
    int x0, y0, xe, ye, n;
    n = 0;
    x0 = 0; y0 = 0; xe = 0; ye = 0;
    if (op == 1) begin
      xe = W; ye = H;
    end else if (op == 2) begin
      x0 = x; y0 = y;
      xe = (x + w < W) ? x + w : W;
      ye = (y + h < H) ? y + h : H;
    end
    for (int yy = y0; yy < ye; yy++) begin
      for (int xx = x0; xx < xe; xx++) begin
        pix_t p;
        p.x = xx; p.y = yy; p.c = c;
        exq[0].push_back(p);
        exq[1].push_back(p);
        n++;
      end
    end
    pend_n[0].push_back(n);
    pend_n[1].push_back(n);
  endtask

  task automatic flush();
    for (int id = 0; id < 2; id++) begin
      exq[id].delete();
      pend_n[id].delete();
      prev_done[id] = 1'b0;
      wcnt[id] = 0;
    end
  endtask

  task automatic issue(input int op, input int x, input int y, input int w, input int h,
                       input int c, input bit hold);
    int k;
    k = 0;
    while (rdy != 2'b11 && k < 30000) begin
      @(posedge clk); #1; k++;
    end
    if (rdy != 2'b11) fail_now("issue_wait_ready");
    cmd_op = 2'(op); cmd_x = 16'(x); cmd_y = 16'(y); cmd_w = 16'(w); cmd_h = 16'(h);
    cmd_color = 3'(c);
    cmd_valid = 1'b1;
    push_model(op, x, y, w, h, c);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!(rdy == 2'b11 && pend_n[0].size() == 0 && pend_n[1].size() == 0) && k < 30000);
    if (k >= 30000) fail_now("wait_idle");
  endtask

  task automatic chk_reset_state();
    for (int id = 0; id < 2; id++) begin
      chk("rst_ready", rdy[id], 1);
      chk("rst_busy", bsy[id], 0);
      chk("rst_done", dn[id], 0);
      chk("rst_we", we[id], 0);
      chk("rst_xyc", {fx[id], fy[id], fc[id]}, 0);
    end
  endtask

  // Monitor: pops the scoreboard on every write and done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      for (int id = 0; id < 2; id++) begin
        pix_t p;
        int n;
        if (prev_done[id]) begin
          chk("ready_after_done", rdy[id], 1);
          prev_done[id] = 1'b0;
        end
        chk("busy_vs_ready", bsy[id], !rdy[id]);
        if (we[id]) begin
          if (exq[id].size() == 0) begin
            fail_now("unexpected_write");
          end else begin
            p = exq[id].pop_front();
            chk("pixel", {fx[id], fy[id], fc[id]}, {16'(p.x), 16'(p.y), 3'(p.c)});
          end
          if (id == 1) chk("write_needs_vblank", vblank, 1);
          if (id == 0) chk("write_cycle", cyc, acc[0] + wcnt[0] + 1);
          wcnt[id]++;
        end
        if (dn[id]) begin
          if (pend_n[id].size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            n = pend_n[id].pop_front();
            chk("done_write_count", wcnt[id], n);
            if (id == 0) chk("done_latency", cyc - acc[0], n + 1);
          end
          last_done[id] = cyc;
          if (id == 0) done_hist.push_back(cyc);
          prev_done[id] = 1'b1;
        end
        if (cmd_valid && rdy[id]) begin
          acc[id] = cyc;
          wcnt[id] = 0;
          if (id == 0) acc_hist.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_w = '0;
    cmd_h = '0; cmd_color = '0; vblank = 1'b1;
    flush();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state();

    // Full-screen clear, ungated.
    vb_mode = 0;
    issue(1, 0, 0, 0, 0, 5, 1'b0);
    wait_idle();

    // Right-edge clipping.
    issue(2, 98, 5, 4, 2, 3, 1'b0);
    wait_idle();

    // Empty / invalid commands.
    issue(2, 10, 10, 0, 5, 1, 1'b0);  wait_idle();
    issue(2, 150, 10, 5, 5, 1, 1'b0); wait_idle();
    issue(3, 1, 1, 5, 5, 1, 1'b0);    wait_idle();
    issue(0, 1, 1, 5, 5, 1, 1'b0);    wait_idle();
    issue(2, 5, 100, 5, 5, 1, 1'b0);  wait_idle();

    // Scripted vblank 0,1,0,1 on the gated instance.
    vb_mode = 2;
    vblank = 1'b0;
    issue(2, 10, 20, 2, 1, 6, 1'b0);
    vblank = 1'b0;
    @(posedge clk); #1 vblank = 1'b1;
    @(posedge clk); #1 vblank = 1'b0;
    @(posedge clk); #1 vblank = 1'b1;
    wait_idle();
    chk("vblank_done_latency", last_done[1] - acc[1], 5);

    // Randomized commands with random vblank.
    vb_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int r, op;
      r = $urandom_range(0, 9);
      op = (r == 0) ? 0 : (r == 1) ? 3 : 2;
      issue(op, $urandom_range(0, 110), $urandom_range(0, 110), $urandom_range(0, 12),
            $urandom_range(0, 12), $urandom_range(0, 7), 1'b0);
      wait_idle();
    end

    // Back-to-back with cmd_valid held.
    vb_mode = 0;
    @(posedge clk); #1;
    acc_hist.delete();
    done_hist.delete();
    issue(2, 0, 0, 3, 2, 2, 1'b1);
    cmd_x = 16'd50; cmd_y = 16'd60; cmd_w = 16'd2; cmd_h = 16'd2; cmd_color = 3'd4;
    push_model(2, 50, 60, 2, 2, 4);
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (rdy != 2'b11 && k < 100);
    if (k >= 100) fail_now("held_wait_ready");
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_idle();
    chk("held_accepts", acc_hist.size(), 2);
    chk("held_dones", done_hist.size(), 2);
    if (acc_hist.size() == 2 && done_hist.size() == 2)
      chk("held_second_accept", acc_hist[1], done_hist[0] + 1);

    // Reset in the middle of a clear.
    issue(1, 0, 0, 0, 0, 7, 1'b0);
    k = 0;
    while (wcnt[0] < 50 && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    chk("writes_before_reset", wcnt[0], 50);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    flush();
    @(negedge clk);
    chk_reset_state();
    repeat (3) @(posedge clk);
    #1;
    issue(2, 40, 40, 5, 3, 1, 1'b0);
    wait_idle();
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_fill_ctrl.md
FB_FILL_CTRL -- requirements
Module: fb_fill_ctrl

Interface
REQ-001 SHALL have parameter XY_BITW, default 16, bit width of all x/y/w/h fields.
REQ-002 SHALL have parameter WIDTH, default 100, framebuffer width in pixels.
REQ-003 SHALL have parameter HEIGHT, default 100, framebuffer height in pixels.
REQ-004 SHALL have parameter COLORW, default 3, color width.
REQ-005 SHALL have parameter VBLANK_ONLY, default 0; when 1, writes are permitted only while vblank=1.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port cmd_valid, input, 1, command present.
REQ-009 SHALL have port cmd_ready, output, 1, block can accept a command.
REQ-010 SHALL have port cmd_op, input, 2, 1=CLEAR, 2=RECT, 0/3=invalid.
REQ-011 SHALL have ports cmd_x, cmd_y, cmd_w, cmd_h, input, XY_BITW each, rectangle origin and size (ignored for CLEAR).
REQ-012 SHALL have port cmd_color, input, COLORW, fill color.
REQ-013 SHALL have port vblank, input, 1, display-timing blanking flag.
REQ-014 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have ports fb_we (1), fb_x (XY_BITW), fb_y (XY_BITW), fb_color (COLORW), outputs, framebuffer write port in framebuffer-local coordinates.

Function
REQ-017 SHALL implement states IDLE, FILL, DONE; cmd_ready=1 only in IDLE.
REQ-018 SHALL accept a command on a cycle with cmd_valid=1 and cmd_ready=1, latching op, origin, clipped extents and color.
REQ-019 SHALL treat CLEAR as RECT with origin (0,0), size WIDTH x HEIGHT.
REQ-020 SHALL clip RECT: x_end=min(cmd_x+cmd_w, WIDTH), y_end=min(cmd_y+cmd_h, HEIGHT), sums computed XY_BITW+1 bits wide with no wrap.
REQ-021 SHALL, for an empty clipped region (cmd_w=0, cmd_h=0, cmd_x>=WIDTH or cmd_y>=HEIGHT) or invalid op, go IDLE->DONE with zero writes.
REQ-022 SHALL otherwise go IDLE->FILL and issue one write per enabled cycle starting the cycle after accept, raster order: x increments first; at x_end-1 x returns to origin x and y increments.
REQ-023 SHALL define write-enable cycle as VBLANK_ONLY=0 or vblank=1; on a non-enabled cycle fb_we=0 and counters hold.
REQ-024 SHALL drive fb_x/fb_y/fb_color with the current pixel whenever fb_we=1; values when fb_we=0 are don't-care.
REQ-025 SHALL transition FILL->DONE on the cycle the last pixel (x_end-1, y_end-1) is written.
REQ-026 SHALL assert done=1 for exactly the single DONE cycle, then return to IDLE; cmd_ready rises the cycle after done.
REQ-027 SHALL have, unstalled, writes in cycles 1..N after accept (N = clipped pixel count), done in cycle N+1, cmd_ready in cycle N+2.
REQ-028 SHALL ignore cmd_* inputs while busy=1; a held cmd_valid is accepted only once back in IDLE.
REQ-029 SHALL never assert fb_we outside FILL and never address x>=WIDTH or y>=HEIGHT.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, enter IDLE regardless of state: cmd_ready=1, busy=0, done=0, fb_we=0, fb_x=0, fb_y=0, fb_color=0.
REQ-031 SHALL abort an in-progress fill on reset with no further writes, and no done pulse for the aborted command.

Verification
REQ-032 CLEAR color 3'b101, VBLANK_ONLY=0 -> 10000 consecutive writes (0,0)..(99,99) raster order, done at cycle 10001, ready at 10002.
REQ-033 RECT x=98,y=5,w=4,h=2 -> writes exactly (98,5),(99,5),(98,6),(99,6), done cycle 5.
REQ-034 RECT w=0 and RECT x=150 and op=3 -> no fb_we, done the cycle after accept, ready the next.
REQ-035 VBLANK_ONLY=1, RECT 2x1, vblank toggling 0,1,0,1 -> writes only on vblank=1 cycles, pixel order preserved, done after second write.
REQ-036 rst asserted mid-CLEAR after 50 writes -> fb_we=0 from next cycle, no done, cmd_ready=1, new RECT then executes normally.
REQ-037 cmd_valid held high across two back-to-back commands -> second accepted only in the cycle cmd_ready returns, no overlap of writes.
